// File: rtl/ultra_pkg.sv
// ultra_pkg: shared carrier constants and scheduler state encoding.
package ultra_pkg;
   localparam int HALF_PERIOD_DEF = 625;
   localparam int PERIOD_CYCLES = 2 * HALF_PERIOD_DEF;
   typedef enum logic [1:0] {IDLE, BURST, DAMP, LISTEN} state_t;
endpackage

// File: rtl/ultrasonic_burst_scheduler_if.sv
// ultrasonic_burst_scheduler_if: host start/done handshake and sweep configuration.
interface ultrasonic_burst_scheduler_if #(
   parameter int NUM_CH = 4,
   parameter int CYC_W  = 8,
   parameter int LST_W  = 16
);
   logic              start;
   logic [CYC_W-1:0]  burst_cycles;
   logic [LST_W-1:0]  listen_periods;
   logic [NUM_CH-1:0] ch_mask;
   logic              busy;
   logic              done;
   modport master (output start, burst_cycles, listen_periods, ch_mask, input busy, done);
   modport slave  (input start, burst_cycles, listen_periods, ch_mask, output busy, done);
endinterface

// File: rtl/ultra_carrier_gen.sv
// ultra_carrier_gen: 50% duty carrier with period-start tick, end-of-period flag and period count.
module ultra_carrier_gen #(
   parameter int HALF  = 625,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             restart,
   input  logic             enable,
   output logic             carrier,
   output logic             tick,
   output logic             wrap,
   output logic [CNT_W-1:0] period
);
   localparam int PW = $clog2(2 * HALF);
   logic [PW-1:0] phase;
   assign wrap    = phase == PW'(2 * HALF - 1);
   assign carrier = enable && phase < PW'(HALF);
   assign tick    = enable && phase == '0;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         phase  <= '0;
         period <= '0;
      end else if (restart) begin
         phase  <= '0;
         period <= '0;
      end else if (enable) begin
         phase <= wrap ? '0 : phase + 1'b1;
         if (wrap) period <= period + 1'b1;
      end
endmodule

// File: rtl/ultrasonic_burst_scheduler.sv
// ultrasonic_burst_scheduler: per-channel 40 kHz burst then listen window, ascending channel order.
// ULTRA_ACTIVE_DAMP_EN inserts an anti-phase DAMP state between BURST and LISTEN.
module ultrasonic_burst_scheduler
   import ultra_pkg::*;
#(
   parameter int HALF_PERIOD = HALF_PERIOD_DEF,
   parameter int NUM_CH      = 4,
   parameter int CH_W        = 2,
   parameter int CYC_W       = 8,
   parameter int LST_W       = 16,
   parameter int DAMP_CYCLES = 2
) (
   input  logic                        clk,
   input  logic                        reset,
   ultrasonic_burst_scheduler_if.slave ctl,
   output logic [NUM_CH-1:0]           tx_drive,
   output logic [CH_W-1:0]             active_ch,
   output logic                        rx_window,
   output logic                        carrier_tick
);
`ifdef ULTRA_ACTIVE_DAMP_EN
   localparam state_t POST_BURST = DAMP;
`else
   localparam state_t POST_BURST = LISTEN;
`endif
   state_t            state, state_nxt;
   logic              restart, carrier, wrap, fin, done_r;
   logic              burst_end, damp_end, listen_end;
   logic [LST_W-1:0]  period, blm1, llm1;
   logic [NUM_CH-1:0] mask_r;
   logic              lo_ok, hi_ok;
   logic [CH_W-1:0]   lo_ch, hi_ch;

   ultra_carrier_gen #(.HALF(HALF_PERIOD), .CNT_W(LST_W)) u_gen (
      .clk(clk), .reset(reset), .restart(restart), .enable(state != IDLE),
      .carrier(carrier), .tick(carrier_tick), .wrap(wrap), .period(period)
   );

   assign burst_end  = wrap && period == blm1;
   assign damp_end   = wrap && period == LST_W'(DAMP_CYCLES - 1);
   assign listen_end = wrap && period == llm1;

   // lo_*: lowest channel of the incoming mask; hi_*: next latched channel above active_ch
   always_comb begin
      lo_ok = 1'b0;
      lo_ch = '0;
      hi_ok = 1'b0;
      hi_ch = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (ctl.ch_mask[i]) begin
            lo_ok = 1'b1;
            lo_ch = CH_W'(i);
         end
         if (mask_r[i] && CH_W'(i) > active_ch) begin
            hi_ok = 1'b1;
            hi_ch = CH_W'(i);
         end
      end
   end

   always_comb begin
      state_nxt = state;
      restart   = 1'b0;
      fin       = 1'b0;
      case (state)
         IDLE: if (ctl.start) begin
            state_nxt = lo_ok ? BURST : IDLE;
            restart   = 1'b1;
            fin       = !lo_ok;
         end
         BURST: if (burst_end) begin
            state_nxt = POST_BURST;
            restart   = 1'b1;
         end
         DAMP: if (damp_end) begin
            state_nxt = LISTEN;
            restart   = 1'b1;
         end
         LISTEN: if (listen_end) begin
            state_nxt = hi_ok ? BURST : IDLE;
            restart   = 1'b1;
            fin       = !hi_ok;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else state <= state_nxt;

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         active_ch <= '0;
         mask_r    <= '0;
         blm1      <= '0;
         llm1      <= '0;
         done_r    <= 1'b0;
      end else begin
         done_r <= fin;
         if (state == IDLE && ctl.start) begin
            mask_r <= ctl.ch_mask;
            blm1   <= LST_W'(ctl.burst_cycles == '0 ? '0 : ctl.burst_cycles - 1'b1);
            llm1   <= ctl.listen_periods == '0 ? '0 : ctl.listen_periods - 1'b1;
            if (lo_ok) active_ch <= lo_ch;
         end else if (state == LISTEN && listen_end && hi_ok) begin
            active_ch <= hi_ch;
         end
      end

   assign tx_drive  = (state == BURST && carrier) || (state == DAMP && !carrier) ? NUM_CH'(1) << active_ch : '0;
   assign rx_window = state == LISTEN;
   assign ctl.busy  = state != IDLE;
   assign ctl.done  = done_r;
endmodule

// File: tb/tb_ultrasonic_burst_scheduler.sv
// tb_ultrasonic_burst_scheduler: directed sweeps with a done-triggered scoreboard of per-sweep statistics.
module tb_ultrasonic_burst_scheduler;
   import ultra_pkg::*;
   localparam int H = 625;
   localparam int P = PERIOD_CYCLES;
`ifdef ULTRA_ACTIVE_DAMP_EN
   localparam int DMP = 2;
`else
   localparam int DMP = 0;
`endif

   typedef struct {
      int         e0;
      int         lat;
      int         ticks;
      int         rx;
      int         txh;
      logic [3:0] chs;
      logic [1:0] last;
      logic [4:0] first;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] tx_drive;
   logic [1:0] active_ch;
   logic       rx_window, carrier_tick;
   exp_t       sb[$];
   int         checks = 0, errors = 0, ecnt = 0;
   logic [1:0] last_ch = 2'd0;
   int         tk, rxc, txc, busyc, bad;
   logic [3:0] chs;
   logic [4:0] first;
   bit         seen;

   ultrasonic_burst_scheduler_if bus ();
   ultrasonic_burst_scheduler dut (
      .clk(clk), .reset(reset), .ctl(bus), .tx_drive(tx_drive),
      .active_ch(active_ch), .rx_window(rx_window), .carrier_tick(carrier_tick)
   );

   always #10 clk = ~clk;
   always @(posedge clk) ecnt <= ecnt + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0d required %0d", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic [3:0] m, input int b, input int l);
      exp_t e;
      int bb, ll;
      e = '{default: 0};
      bb = b == 0 ? 1 : b;
      ll = l == 0 ? 1 : l;
      e.last = last_ch;
      for (int i = 0; i < 4; i++)
         if (m[i]) begin
            e.ticks += bb + ll + DMP;
            e.rx    += ll * P;
            e.txh   += (bb + DMP) * H;
            e.lat   += (bb + ll + DMP) * P;
            e.last   = 2'(i);
            if (e.first == 5'd0) e.first = {1'b1, 4'(1 << i)};
         end
      e.chs = m;
      return e;
   endfunction

   task automatic clear_stats();
      tk = 0; rxc = 0; txc = 0; busyc = 0; bad = 0; chs = 4'd0; first = 5'd0; seen = 1'b0;
   endtask

   // monitor: accumulates one sweep, scores it against the queue head on done
   always @(negedge clk) begin
      exp_t e;
      if (reset) clear_stats();
      else if (bus.done) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done at edge %0d", ecnt);
         end else begin
            e = sb.pop_front();
            chk("latency", ecnt - e.e0, e.lat);
            chk("ticks", tk, e.ticks);
            chk("rx_cycles", rxc, e.rx);
            chk("tx_high_cycles", txc, e.txh);
            chk("busy_cycles", busyc, e.lat);
            chk("channels_driven", int'(chs), int'(e.chs));
            chk("active_ch_hold", int'(active_ch), int'(e.last));
            chk("first_cycle", int'(first), int'(e.first));
            chk("bad_drive", bad, 0);
            chk("busy_at_done", int'(bus.busy), 0);
         end
         clear_stats();
      end else begin
         if (carrier_tick) tk++;
         if (rx_window) rxc++;
         if (tx_drive != 4'd0) txc++;
         if (bus.busy) busyc++;
         if ((tx_drive != 4'd0 && tx_drive != (4'b0001 << active_ch)) || (rx_window && tx_drive != 4'd0)) bad++;
         chs = chs | tx_drive;
         if (bus.busy && !seen) begin
            seen = 1'b1;
            first = {carrier_tick, tx_drive};
         end
      end
   end

   task automatic sweep(input logic [3:0] m, input int b, input int l, input bit push);
      exp_t e;
      @(negedge clk);
      bus.start = 1'b1;
      bus.ch_mask = m;
      bus.burst_cycles = 8'(b);
      bus.listen_periods = 16'(l);
      if (push) begin
         e = mk(m, b, l);
         e.e0 = ecnt + 1;
         sb.push_back(e);
         last_ch = e.last;
      end
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 20000 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL timeout waiting for done, pending %0d", sb.size());
         sb.delete();
      end
      repeat (5) @(negedge clk);
   endtask

   initial begin
      bus.start = 1'b0;
      bus.ch_mask = 4'd0;
      bus.burst_cycles = 8'd0;
      bus.listen_periods = 16'd0;
      repeat (3) @(negedge clk);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_done", int'(bus.done), 0);
      chk("rst_tx", int'(tx_drive), 0);
      chk("rst_rx", int'(rx_window), 0);
      chk("rst_tick", int'(carrier_tick), 0);
      chk("rst_ch", int'(active_ch), 0);
      reset = 1'b0;
      sweep(4'b0001, 3, 2, 1);
      wait_done();
      sweep(4'b0101, 1, 1, 1);
      wait_done();
      sweep(4'b0000, 3, 3, 1);
      wait_done();
      sweep(4'b1000, 0, 0, 1);
      wait_done();
      // start and config change mid-burst must be ignored
      sweep(4'b0001, 2, 1, 1);
      repeat (1000) @(negedge clk);
      bus.start = 1'b1;
      bus.ch_mask = 4'b1111;
      bus.burst_cycles = 8'd5;
      bus.listen_periods = 16'd7;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done();
      // async reset in the high half of a burst period
      sweep(4'b0010, 4, 1, 0);
      chk("pre_reset_tx", int'(tx_drive), 2);
      @(posedge clk);
      #3 reset = 1'b1;
      #1;
      chk("async_tx", int'(tx_drive), 0);
      chk("async_busy", int'(bus.busy), 0);
      chk("async_rx", int'(rx_window), 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      last_ch = 2'd0;
      chk("post_reset_ch", int'(active_ch), 0);
      sweep(4'b0010, 1, 2, 1);
      wait_done();
      chk("sb_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
